// File: rtl/special_queue_p.sv
// special_queue_p: selectable-removal queue. Entries are appended at the tail.
// Any single occupied entry can be removed through a one-hot select, and the
// younger entries then compact toward the head (index 0 is always the oldest).
module special_queue_p #(
    parameter int DATA_W   = 6,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DEPTH-1:0]  rd_sel,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [CNT_W-1:0]  count,
    output logic              push_err,
    output logic              pop_err
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] mem_nx_s [DEPTH];
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nx_s;
    logic [CNT_W-1:0]  sel_idx_s;
    logic [CNT_W-1:0]  wr_idx_s;
    logic [DATA_W-1:0] pop_data_s;
    logic              sel_onehot_s;
    logic              legal_pop_s;
    logic              legal_push_s;

    // Decode the pop select, qualify push/pop and compute the next queue image.
    always_comb begin
        sel_idx_s    = {CNT_W{1'b0}};
        pop_data_s   = {DATA_W{1'b0}};
        sel_onehot_s = (rd_sel != {DEPTH{1'b0}}) &&
                       ((rd_sel & (rd_sel - {{(DEPTH-1){1'b0}}, 1'b1})) == {DEPTH{1'b0}});
        // With a one-hot select these OR-reductions yield the index and its data.
        for (int i = 0; i < DEPTH; i++) begin
            sel_idx_s  = sel_idx_s  | (rd_sel[i] ? CNT_W'(i) : {CNT_W{1'b0}});
            pop_data_s = pop_data_s | (rd_sel[i] ? mem_r[i] : {DATA_W{1'b0}});
        end
        legal_pop_s  = pop && sel_onehot_s && (sel_idx_s < count_r);
        legal_push_s = push && ((count_r != CNT_FULL) || legal_pop_s);

        case ({legal_push_s, legal_pop_s})
            2'b10:   count_nx_s = count_r + CNT_ONE;
            2'b01:   count_nx_s = count_r - CNT_ONE;
            default: count_nx_s = count_r;
        endcase

        // Compaction: entries at and above the removed one move down by one.
        for (int i = 0; i < DEPTH; i++) begin
            mem_nx_s[i] = mem_r[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (legal_pop_s && (CNT_W'(i) >= sel_idx_s) && (CNT_W'(i) < (count_r - CNT_ONE))) begin
                mem_nx_s[i] = mem_r[i + 1];
            end else begin
                mem_nx_s[i] = mem_nx_s[i];
            end
        end

        // The new tail sits one lower when a pop frees a slot in the same cycle.
        wr_idx_s = legal_pop_s ? (count_r - CNT_ONE) : count_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (legal_push_s && (wr_idx_s == CNT_W'(i))) begin
                mem_nx_s[i] = data_in;
            end else begin
                mem_nx_s[i] = mem_nx_s[i];
            end
        end
    end

    // Storage array; contents are don't-care after reset because count gates them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= mem_nx_s[i];
        end
    end

    // Occupancy, flags, popped data and event strobes, all registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r     <= {CNT_W{1'b0}};
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= (AF_LEVEL == 0);
            data_out    <= {DATA_W{1'b0}};
            out_valid   <= 1'b0;
            push_err    <= 1'b0;
            pop_err     <= 1'b0;
        end else begin
            count_r     <= count_nx_s;
            full        <= (count_nx_s == CNT_FULL);
            empty       <= (count_nx_s == {CNT_W{1'b0}});
            almost_full <= (count_nx_s >= CNT_AF);
            data_out    <= legal_pop_s ? pop_data_s : data_out;
            out_valid   <= legal_pop_s;
            push_err    <= push && !legal_push_s;
            pop_err     <= pop && !legal_pop_s;
        end
    end

    assign count = count_r;

endmodule

// File: tb/tb_special_queue_p.sv
// Directed bench for special_queue_p: a vector table on the default 6x4
// configuration plus a hand-written scaling sequence on a 16x8 instance.
module tb_special_queue_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration (DATA_W=6, DEPTH=4, AF_LEVEL=3)
    logic       a_rst_n, a_push, a_pop;
    logic [5:0] a_din, a_dout;
    logic [3:0] a_sel;
    logic       a_ov, a_full, a_empty, a_af, a_perr, a_poerr;
    logic [2:0] a_cnt;

    special_queue_p u_a (
        .clk(clk), .rst_n(a_rst_n), .push(a_push), .pop(a_pop),
        .data_in(a_din), .rd_sel(a_sel), .data_out(a_dout), .out_valid(a_ov),
        .full(a_full), .empty(a_empty), .almost_full(a_af), .count(a_cnt),
        .push_err(a_perr), .pop_err(a_poerr)
    );

    // Scaled configuration (DATA_W=16, DEPTH=8, AF_LEVEL=6)
    logic        b_rst_n, b_push, b_pop;
    logic [15:0] b_din, b_dout;
    logic [7:0]  b_sel;
    logic        b_ov, b_full, b_empty, b_af, b_perr, b_poerr;
    logic [3:0]  b_cnt;

    special_queue_p #(.DATA_W(16), .DEPTH(8), .AF_LEVEL(6)) u_b (
        .clk(clk), .rst_n(b_rst_n), .push(b_push), .pop(b_pop),
        .data_in(b_din), .rd_sel(b_sel), .data_out(b_dout), .out_valid(b_ov),
        .full(b_full), .empty(b_empty), .almost_full(b_af), .count(b_cnt),
        .push_err(b_perr), .pop_err(b_poerr)
    );

    typedef struct {
        logic       rst_n;
        logic       push;
        logic       pop;
        logic [5:0] din;
        logic [3:0] sel;
        int         cnt;
        logic [5:0] dout;
        logic       ov;
        logic       perr;
        logic       poerr;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input logic r, input logic pu, input logic po,
                       input logic [5:0] d, input logic [3:0] s, input int c,
                       input logic [5:0] dout, input logic ov,
                       input logic perr, input logic poerr);
        vec_t v;
        v.rst_n = r; v.push = pu; v.pop = po; v.din = d; v.sel = s;
        v.cnt = c; v.dout = dout; v.ov = ov; v.perr = perr; v.poerr = poerr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        a_rst_n = 1'b0; a_push = 1'b0; a_pop = 1'b0; a_din = 6'd0; a_sel = 4'd0;
        b_rst_n = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_din = 16'd0; b_sel = 8'd0;

        // rst push pop din sel     | cnt dout ov perr poerr
        add(0, 0, 0,  0, 4'b0000,  0,  0, 0, 0, 0);   // reset state
        add(1, 1, 0, 62, 4'b0000,  1,  0, 0, 0, 0);   // fill
        add(1, 1, 0, 61, 4'b0000,  2,  0, 0, 0, 0);
        add(1, 1, 0, 59, 4'b0000,  3,  0, 0, 0, 0);   // almost_full rises
        add(1, 1, 0, 55, 4'b0000,  4,  0, 0, 0, 0);   // full
        add(1, 1, 0, 60, 4'b0000,  4,  0, 0, 1, 0);   // overflow dropped
        add(1, 1, 1, 33, 4'b0011,  4,  0, 0, 1, 1);   // full + bad select: both errors
        add(1, 0, 1,  0, 4'b0010,  3, 61, 1, 0, 0);   // middle removal
        add(1, 0, 1,  0, 4'b0100,  2, 55, 1, 0, 0);   // -> 62,59
        add(1, 0, 1,  0, 4'b0001,  1, 62, 1, 0, 0);
        add(1, 0, 1,  0, 4'b0001,  0, 59, 1, 0, 0);
        add(1, 1, 0, 25, 4'b0000,  1, 59, 0, 0, 0);
        add(1, 1, 0, 26, 4'b0000,  2, 59, 0, 0, 0);
        add(1, 1, 0, 27, 4'b0000,  3, 59, 0, 0, 0);
        add(1, 1, 0, 28, 4'b0000,  4, 59, 0, 0, 0);
        add(1, 1, 1, 29, 4'b1000,  4, 28, 1, 0, 0);   // push+pop when full
        add(1, 0, 1,  0, 4'b1000,  3, 29, 1, 0, 0);   // new tail is 29
        add(1, 0, 1,  0, 4'b0100,  2, 27, 1, 0, 0);
        add(1, 0, 1,  0, 4'b0001,  1, 25, 1, 0, 0);
        add(1, 0, 1,  0, 4'b0001,  0, 26, 1, 0, 0);
        add(1, 1, 0, 10, 4'b0000,  1, 26, 0, 0, 0);
        add(1, 1, 0, 12, 4'b0000,  2, 26, 0, 0, 0);
        add(1, 0, 1,  0, 4'b0100,  2, 26, 0, 0, 1);   // k >= count
        add(1, 0, 1,  0, 4'b0011,  2, 26, 0, 0, 1);   // two bits set
        add(1, 0, 1,  0, 4'b0000,  2, 26, 0, 0, 1);   // zero select
        add(1, 0, 1,  0, 4'b0001,  1, 10, 1, 0, 0);   // contents unchanged
        add(1, 0, 1,  0, 4'b0001,  0, 12, 1, 0, 0);
        add(1, 0, 1,  0, 4'b0001,  0, 12, 0, 0, 1);   // pop on empty
        add(1, 1, 1,  7, 4'b0001,  1, 12, 0, 0, 1);   // same-cycle push not poppable
        add(1, 0, 1,  0, 4'b0001,  0,  7, 1, 0, 0);
        add(1, 1, 0,  1, 4'b0000,  1,  7, 0, 0, 0);
        add(1, 1, 0,  2, 4'b0000,  2,  7, 0, 0, 0);
        add(1, 1, 0,  3, 4'b0000,  3,  7, 0, 0, 0);
        add(0, 1, 1,  9, 4'b0001,  0,  0, 0, 0, 0);   // reset mid-operation
        add(1, 1, 0, 10, 4'b0000,  1,  0, 0, 0, 0);
        add(1, 0, 1,  0, 4'b0001,  0, 10, 1, 0, 0);
        add(1, 0, 0,  0, 4'b0000,  0, 10, 0, 0, 0);   // strobes are single-cycle

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            a_rst_n = vecs[i].rst_n; a_push = vecs[i].push; a_pop = vecs[i].pop;
            a_din = vecs[i].din; a_sel = vecs[i].sel;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d count", i),      32'(a_cnt),   32'(vecs[i].cnt));
            chk($sformatf("v%0d data_out", i),   32'(a_dout),  32'(vecs[i].dout));
            chk($sformatf("v%0d out_valid", i),  32'(a_ov),    32'(vecs[i].ov));
            chk($sformatf("v%0d push_err", i),   32'(a_perr),  32'(vecs[i].perr));
            chk($sformatf("v%0d pop_err", i),    32'(a_poerr), 32'(vecs[i].poerr));
            chk($sformatf("v%0d full", i),        32'(a_full),  32'(vecs[i].cnt == 4));
            chk($sformatf("v%0d empty", i),       32'(a_empty), 32'(vecs[i].cnt == 0));
            chk($sformatf("v%0d almost_full", i), 32'(a_af),    32'(vecs[i].cnt >= 3));
        end
        a_push = 1'b0; a_pop = 1'b0;

        // Scaling sequence on the 16x8 instance
        b_rst_n = 1'b0;
        @(posedge clk); #1;
        chk("b reset empty", 32'(b_empty), 32'd1);
        b_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_push = 1'b1; b_din = 16'h0100 + 16'(i);
            @(posedge clk); #1;
            chk($sformatf("b push%0d count", i), 32'(b_cnt),  32'(i + 1));
            chk($sformatf("b push%0d af", i),    32'(b_af),   32'(i >= 5));
            chk($sformatf("b push%0d full", i),  32'(b_full), 32'(i == 7));
        end
        b_push = 1'b0;
        b_pop = 1'b1; b_sel = 8'h80;
        @(posedge clk); #1;
        chk("b pop tail data", 32'(b_dout), 32'h0107);
        chk("b pop tail ov",   32'(b_ov),   32'd1);
        chk("b pop tail cnt",  32'(b_cnt),  32'd7);
        b_sel = 8'h01;
        @(posedge clk); #1;
        chk("b pop head data", 32'(b_dout), 32'h0100);
        chk("b pop head cnt",  32'(b_cnt),  32'd6);
        @(posedge clk); #1;
        chk("b new head data", 32'(b_dout), 32'h0101);
        b_pop = 1'b0;
        @(posedge clk); #1;
        chk("b ov drops", 32'(b_ov), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
